// File: rtl/alu_pkg.sv
// Shared widths, opcode encoding, FSM state encoding and bus payload types
// for the ALU sequencer and its datapath.
package alu_pkg;

  localparam int unsigned DATA_W  = 20;
  localparam int unsigned ADDR_W  = 3;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SHAMT_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_OP_NOT  = 4'd0,
    ALU_OP_AND  = 4'd1,
    ALU_OP_OR   = 4'd2,
    ALU_OP_XOR  = 4'd3,
    ALU_OP_SHL  = 4'd4,
    ALU_OP_SHR  = 4'd5,
    ALU_OP_ROTL = 4'd6,
    ALU_OP_ROTR = 4'd7,
    ALU_OP_SWAP = 4'd8,
    ALU_OP_INC  = 4'd9,
    ALU_OP_DEC  = 4'd10,
    ALU_OP_ADD  = 4'd11,
    ALU_OP_ADDC = 4'd12,
    ALU_OP_SUB  = 4'd13,
    ALU_OP_EQ   = 4'd14,
    ALU_OP_LT   = 4'd15
  } alu_op_e;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_READ   = 3'd1;
  localparam state_t ST_EXEC   = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_WRITE2 = 3'd4;

  typedef struct packed {
    logic zero;
    logic sign;
    logic carry;
  } alu_flags_t;

  typedef struct packed {
    alu_op_e             op;
    logic [ADDR_W-1:0]   rd;
    logic [ADDR_W-1:0]   rs;
    logic [SHAMT_W-1:0]  shamt;
  } alu_instr_t;

  // Compare ops only update flags; every other op writes rd.
  function automatic logic op_writes_rd(input alu_op_e op);
    return !((op == ALU_OP_EQ) || (op == ALU_OP_LT));
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational op evaluation: produces the result word and the next flag
// values from the latched operands and the current flags.
module alu_datapath
  import alu_pkg::*;
(
  input  alu_op_e             op,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [SHAMT_W-1:0]  shamt,
  input  alu_flags_t          flags_in,
  output logic [DATA_W-1:0]   result_c,
  output alu_flags_t          flags_c
);

  localparam int unsigned SUM_W = DATA_W + 1;

  logic [SUM_W-1:0] sum_c;

  always_comb begin
    result_c = '0;
    flags_c  = flags_in;
    sum_c    = '0;

    case (op)
      ALU_OP_NOT:  result_c = ~a;
      ALU_OP_AND:  result_c = a & b;
      ALU_OP_OR:   result_c = a | b;
      ALU_OP_XOR:  result_c = a ^ b;
      ALU_OP_SHL:  result_c = a << shamt;
      ALU_OP_SHR:  result_c = a >> shamt;
      ALU_OP_ROTL: result_c = {a[DATA_W-2:0], a[DATA_W-1]};
      ALU_OP_ROTR: result_c = {a[0], a[DATA_W-1:1]};
      ALU_OP_SWAP: result_c = b;
      ALU_OP_INC:  result_c = a + DATA_W'(1);
      ALU_OP_DEC:  result_c = a - DATA_W'(1);
      ALU_OP_ADD: begin
        sum_c         = SUM_W'(a) + SUM_W'(b);
        result_c      = sum_c[DATA_W-1:0];
        flags_c.carry = sum_c[DATA_W];
      end
      ALU_OP_ADDC: begin
        sum_c         = SUM_W'(a) + SUM_W'(b) + SUM_W'(flags_in.carry);
        result_c      = sum_c[DATA_W-1:0];
        flags_c.carry = sum_c[DATA_W];
      end
      ALU_OP_SUB: begin
        result_c      = a - b;
        flags_c.carry = (a < b);
      end
      ALU_OP_EQ:   result_c = a ^ b;
      ALU_OP_LT:   result_c = a - b;
      default:     result_c = '0;
    endcase

    // Compares report on the operands; writing ops report on the result.
    if (op == ALU_OP_EQ) begin
      flags_c.zero = (a == b);
    end else if (op == ALU_OP_LT) begin
      flags_c.zero = (a == b);
      flags_c.sign = (a < b);
    end else begin
      flags_c.zero = (result_c == '0);
      flags_c.sign = result_c[DATA_W-1];
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: instruction handshake, register file, flag
// registers and the IDLE/READ/EXEC/WRITE/WRITE2 control FSM.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned REG_COUNT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OP_W-1:0]     instr_op,
  input  logic [ADDR_W-1:0]   instr_rd,
  input  logic [ADDR_W-1:0]   instr_rs,
  input  logic [SHAMT_W-1:0]  instr_shamt,
  input  logic                ld_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]   result,
  output logic                flag_zero,
  output logic                flag_sign,
  output logic                flag_carry,
  output logic                done
);

  state_t             state_q;
  state_t             state_d;
  alu_instr_t         instr_q;
  logic [DATA_W-1:0]  a_q;
  logic [DATA_W-1:0]  b_q;
  logic [DATA_W-1:0]  result_q;
  alu_flags_t         flags_q;
  logic               done_q;
  logic               done_d;
  logic [DATA_W-1:0]  regs [REG_COUNT];

  logic               handshake_c;
  logic               reg_we_c;
  logic [ADDR_W-1:0]  reg_waddr_c;
  logic [DATA_W-1:0]  reg_wdata_c;
  logic [DATA_W-1:0]  alu_result_c;
  alu_flags_t         alu_flags_c;

  assign instr_ready = (state_q == ST_IDLE) && !ld_en;
  assign handshake_c = instr_valid && instr_ready;

  alu_datapath u_datapath (
    .op       (instr_q.op),
    .a        (a_q),
    .b        (b_q),
    .shamt    (instr_q.shamt),
    .flags_in (flags_q),
    .result_c (alu_result_c),
    .flags_c  (alu_flags_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, done pulse and the single register-file write port.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    reg_we_c    = 1'b0;
    reg_waddr_c = '0;
    reg_wdata_c = '0;

    case (state_q)
      ST_IDLE: begin
        if (ld_en) begin
          reg_we_c    = 1'b1;
          reg_waddr_c = ld_addr;
          reg_wdata_c = ld_data;
        end
        if (handshake_c) state_d = ST_READ;
      end
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_WRITE;
        done_d  = (instr_q.op != ALU_OP_SWAP);
      end
      ST_WRITE: begin
        reg_we_c    = op_writes_rd(instr_q.op);
        reg_waddr_c = instr_q.rd;
        reg_wdata_c = result_q;
        if (instr_q.op == ALU_OP_SWAP) begin
          state_d = ST_WRITE2;
          done_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE2: begin
        reg_we_c    = 1'b1;
        reg_waddr_c = instr_q.rs;
        reg_wdata_c = a_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      done_q <= done_d;
      if (handshake_c) begin
        instr_q <= '{op: alu_op_e'(instr_op), rd: instr_rd, rs: instr_rs, shamt: instr_shamt};
      end
      if (state_q == ST_READ) begin
        a_q <= regs[instr_q.rd];
        b_q <= regs[instr_q.rs];
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_result_c;
        flags_q  <= alu_flags_c;
      end
      if (reg_we_c) regs[reg_waddr_c] <= reg_wdata_c;
    end
  end

  assign rd_data    = regs[rd_addr];
  assign result     = result_q;
  assign flag_zero  = flags_q.zero;
  assign flag_sign  = flags_q.sign;
  assign flag_carry = flags_q.carry;
  assign done       = done_q;

endmodule
